// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// registers the fetched word into IF/ID. Redirects come from the instruction
// currently in ID (i.e. held in IF/ID), giving one architectural delay slot.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] link_addr,
  output logic        addr_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifIdInstr_q, ifIdInstr_d;
  logic [31:0] ifIdPc4_q, ifIdPc4_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic        addrErr_q, addrErr_d;

  logic [31:0] pcPlus4;
  logic [31:0] brOffset;
  logic [31:0] brTarget;
  logic [31:0] jmpTarget;
  logic [31:0] jrAligned;

  // Candidate next-PC values. Branch and jump targets are relative to the
  // PC+4 of the instruction sitting in ID, not to the current fetch PC.
  assign pcPlus4   = pc_q + 32'd4;
  assign brOffset  = {{14{br_imm[15]}}, br_imm, 2'b00};
  assign brTarget  = ifIdPc4_q + brOffset;
  assign jmpTarget = {ifIdPc4_q[31:28], jmp_index, 2'b00};
  assign jrAligned = {jr_target[31:2], 2'b00};

  // Next PC: hold while stalled, otherwise jr > jmp > branch > sequential.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (jr) begin
        pc_d = jrAligned;
      end else if (jmp) begin
        pc_d = jmpTarget;
      end else if (br_taken) begin
        pc_d = brTarget;
      end else begin
        pc_d = pcPlus4;
      end
    end
  end

  // IF/ID next state: flush injects a bubble even under stall; a misaligned
  // jr only counts as an error when it is actually accepted (not stalled).
  always_comb begin
    ifIdInstr_d = ifIdInstr_q;
    ifIdPc4_d   = ifIdPc4_q;
    ifIdValid_d = ifIdValid_q;
    addrErr_d   = !stall && jr && (jr_target[1:0] != 2'b00);
    if (flush) begin
      ifIdInstr_d = NOP_WORD;
      ifIdPc4_d   = 32'd0;
      ifIdValid_d = 1'b0;
    end else if (!stall) begin
      ifIdInstr_d = imem_data;
      ifIdPc4_d   = pcPlus4;
      ifIdValid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ifIdInstr_q <= NOP_WORD;
      ifIdPc4_q   <= 32'd0;
      ifIdValid_q <= 1'b0;
      addrErr_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdPc4_q   <= ifIdPc4_d;
      ifIdValid_q <= ifIdValid_d;
      addrErr_q   <= addrErr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = ifIdInstr_q;
  assign if_id_pc4   = ifIdPc4_q;
  assign if_id_valid = ifIdValid_q;
  assign link_addr   = ifIdPc4_q + 32'd4;
  assign addr_err    = addrErr_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline.
- Owns the PC and drives the address side of the instruction memory, which returns the instruction word combinationally in the same cycle.
- Registers the fetched word into the IF/ID pipeline register.
- Applies stall, flush and redirects resolved in ID (branch, J/JAL, JR) with one architectural delay slot.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded at reset.
- NOP_WORD, 32'h00000000, instruction word injected into IF/ID on reset or flush.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_addr  output  32  fetch address; equals the PC register.
- imem_data  input  32  instruction word at imem_addr, valid in the same cycle.
- stall  input  1  hold PC and IF/ID.
- flush  input  1  replace the IF/ID contents with a bubble.
- br_taken  input  1  conditional branch in ID is taken.
- br_imm  input  16  branch offset field of the ID instruction.
- jmp  input  1  J/JAL in ID.
- jmp_index  input  26  jump index field of the ID instruction.
- jr  input  1  JR in ID.
- jr_target  input  32  register value for JR.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc4  output  32  IF/ID PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- link_addr  output  32  JAL link value, if_id_pc4+4 (skips the delay slot); combinational.
- addr_err  output  1  one-cycle pulse on a misaligned JR target.

Behaviour:
- Reset (rst_n=0 at an edge):
  - PC=RESET_PC.
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, addr_err=0.
  - Reset overrides all other inputs, including mid-redirect.
- imem_addr=PC at all times. No fetch latency: imem_data is sampled at the same edge that updates the PC.
- Next-PC priority (redirect inputs come from the instruction held in IF/ID):
  1. jr: jr_target with bits[1:0] forced to 00.
  2. jmp: {if_id_pc4[31:28], jmp_index, 2'b00}.
  3. br_taken: if_id_pc4 + (sign_extend(br_imm) << 2), 32-bit wrap.
  4. Otherwise: PC+4, 32-bit wrap (0xFFFFFFFC -> 0).
- Delay slot: the word fetched in the redirect cycle still enters IF/ID with valid=1. No automatic squash.
- When stall=1:
  - PC and IF/ID hold.
  - Redirect inputs are ignored that cycle. ID keeps them asserted until the stall drops.
  - addr_err is not raised.
- When flush=1:
  - IF/ID is loaded with NOP_WORD and valid=0, pc4=0. This wins over stall for the IF/ID register.
  - The PC update still follows stall and the priority list. flush does not freeze the PC.
- Normal cycle (no stall, no flush): if_id_instr=imem_data, if_id_pc4=PC+4, if_id_valid=1.
- addr_err: 1 for exactly the cycle after an accepted jr with jr_target[1:0]!=0, else 0.
- Multiple redirect inputs asserted together is legal. Priority resolves them with no error.
- Only the PC register, the IF/ID registers and addr_err hold state. Everything else is combinational.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: hold rst_n=0 for 2 cycles, then release. Memory returns 0x20100000 at 0x3000 and 0x20110000 at 0x3004.
  - Required: imem_addr=0x3000 then 0x3004 then 0x3008. if_id_instr=0x20100000 with if_id_pc4=0x3004 and valid=1 after the first edge post-release.
- Taken branch with delay slot:
  - Stimulus: IF/ID holds 0x12280006 with pc4=0x3014; assert br_taken, br_imm=0x0006.
  - Required: next PC=0x302C. The delay-slot word at 0x3014 enters IF/ID with valid=1.
  - Negative offset: br_imm=0xFFFF gives 0x3010.
- JAL:
  - Stimulus: IF/ID holds 0x0C000C04 with pc4=0x3028; assert jmp, jmp_index=0x000C04.
  - Required: next PC=0x3010, link_addr=0x302C.
  - Same cycle with br_taken=1 also asserted: PC still 0x3010.
- Stall and flush:
  - Stall=1 for 3 cycles: imem_addr and IF/ID unchanged; a jr asserted during the stall has no effect.
  - flush=1 together with stall=1: IF/ID becomes NOP_WORD with valid=0 while PC holds.
- JR alignment:
  - jr_target=0x00003043: PC=0x3040, addr_err=1 for one cycle.
  - jr_target=0x0000306C: PC=0x306C, addr_err=0.
- Wrap and reset mid-redirect:
  - PC=0xFFFFFFFC with no redirect: next PC=0x00000000.
  - rst_n=0 in the same cycle as jmp=1: PC=RESET_PC and IF/ID=NOP_WORD with valid=0.
